// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use stall and branch flush control
// for a 5-stage RV32I pipeline, with saturating stall/flush counters.
module hazard_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic              is_load_d,
  input  logic              pc_src_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
  } ex_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } wr_t;

  ex_t              ex_q, ex_d;
  wr_t              mem_q, mem_d;
  wr_t              wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall;
  logic             branch;

  // Newest producer wins: MEM before WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input wr_t mem, input wr_t wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != '0 && mem.regwrite && mem.rd == rs)
      sel = FWD_MEM;
    else if (rs != '0 && wb.regwrite && wb.rd == rs)
      sel = FWD_WB;
    return sel;
  endfunction

  // Hazard detection and control outputs; a taken branch overrides the stall.
  always_comb begin
    branch   = pc_src_e & ~rst;
    lw_stall = ex_q.is_load && ex_q.regwrite && (ex_q.rd != '0) &&
               ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));
    fwd_a_e  = fwd_sel(ex_q.rs1, mem_q, wb_q);
    fwd_b_e  = fwd_sel(ex_q.rs2, mem_q, wb_q);
    stall_f  = lw_stall & ~branch;
    stall_d  = lw_stall & ~branch;
    flush_d  = branch;
    flush_e  = lw_stall | branch;
  end

  // Shadow pipeline advance and saturating counter next-state.
  always_comb begin
    ex_d        = '0;
    mem_d       = '0;
    wb_d        = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!flush_e) begin
      ex_d.rs1      = rs1_d;
      ex_d.rs2      = rs2_d;
      ex_d.rd       = rd_d;
      ex_d.regwrite = regwrite_d;
      ex_d.is_load  = is_load_d;
    end
    mem_d.rd       = ex_q.rd;
    mem_d.regwrite = ex_q.regwrite;
    wb_d           = mem_q;
    if (stall_d && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit: forwarding, load-use, x0, branch, reset, saturation.
`timescale 1ns/1ps
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       regwrite_d, is_load_d, pc_src_e;

  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [31:0] stall_cnt, flush_cnt;

  logic [1:0]  s_fwd_a_e, s_fwd_b_e;
  logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .is_load_d(is_load_d), .pc_src_e(pc_src_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.REG_AW(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .is_load_d(is_load_d), .pc_src_e(pc_src_e),
    .fwd_a_e(s_fwd_a_e), .fwd_b_e(s_fwd_b_e), .stall_f(s_stall_f), .stall_d(s_stall_d),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Advance one cycle; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic pc);
    rs1_d = rs1; rs2_d = rs2; rd_d = rd; regwrite_d = rw; is_load_d = ld; pc_src_e = pc;
  endtask

  task automatic nops(input int n);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    @(negedge clk);
    n_tests++;
    if ({fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e});
    end
    n_tests++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    tick();
    pc_src_e = 1'b0;
    rst = 1'b0;
    nops(3);
  endtask

  task automatic test_ex_forward();
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
    tick();
    drive(5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);   // sub x8, x5, x6
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (fwd_a_e !== 2'b10) begin
      n_fail++; $display("FAIL ex_fwd_a: got %b expected 10", fwd_a_e);
    end
    n_tests++;
    if (fwd_b_e !== 2'b00) begin
      n_fail++; $display("FAIL ex_fwd_b: got %b expected 00", fwd_b_e);
    end
    tick();
    nops(3);
  endtask

  task automatic test_wb_priority();
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);   // N writes x5
    tick();
    drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);   // N+1 writes x5
    tick();
    drive(5'd0, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);   // N+2 reads x5 via rs2
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (fwd_b_e !== 2'b10) begin
      n_fail++; $display("FAIL mem_priority_b: got %b expected 10", fwd_b_e);
    end
    n_tests++;
    if (fwd_a_e !== 2'b00) begin
      n_fail++; $display("FAIL mem_priority_a: got %b expected 00", fwd_a_e);
    end
    tick();
    nops(3);
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);   // N writes x5
    tick();
    drive(5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0);   // N+1 does not write
    tick();
    drive(5'd0, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (fwd_b_e !== 2'b01) begin
      n_fail++; $display("FAIL wb_fwd_b: got %b expected 01", fwd_b_e);
    end
    tick();
    nops(3);
  endtask

  task automatic test_load_use();
    drive(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);   // lw x7
    tick();
    drive(5'd7, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);   // add x8, x7, x3
    @(negedge clk);
    n_tests++;
    if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin
      n_fail++;
      $display("FAIL lu_stall: got %b expected 1110", {stall_f, stall_d, flush_e, flush_d});
    end
    tick();                                       // consumer held in ID
    @(negedge clk);
    n_tests++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      n_fail++;
      $display("FAIL lu_one_bubble: got %b expected 000", {stall_f, stall_d, flush_e});
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (fwd_a_e !== 2'b01) begin
      n_fail++; $display("FAIL lu_fwd_a: got %b expected 01", fwd_a_e);
    end
    n_tests++;
    if (stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt);
    end
    tick();
    nops(3);
  endtask

  task automatic test_x0_guard();
    drive(5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0
    tick();
    drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);   // use x0
    @(negedge clk);
    n_tests++;
    if ({stall_d, flush_e} !== 2'b00) begin
      n_fail++; $display("FAIL x0_no_stall: got %b expected 00", {stall_d, flush_e});
    end
    tick();
    nops(3);
    drive(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);   // addi x0
    tick();
    drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);   // use x0
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if ({fwd_a_e, fwd_b_e} !== 4'b0000) begin
      n_fail++; $display("FAIL x0_no_fwd: got %b expected 0000", {fwd_a_e, fwd_b_e});
    end
    tick();
    nops(3);
  endtask

  task automatic test_branch();
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
    tick();
    drive(5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);   // wrong-path reader, branch taken
    @(negedge clk);
    n_tests++;
    if ({flush_d, flush_e, stall_f, stall_d} !== 4'b1100) begin
      n_fail++;
      $display("FAIL br_flush: got %b expected 1100", {flush_d, flush_e, stall_f, stall_d});
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (fwd_a_e !== 2'b00) begin
      n_fail++; $display("FAIL br_bubble_fwd: got %b expected 00", fwd_a_e);
    end
    n_tests++;
    if (flush_cnt !== 32'd1) begin
      n_fail++; $display("FAIL br_flush_cnt: got %0d expected 1", flush_cnt);
    end
    tick();
    nops(3);
    drive(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);   // lw x7
    tick();
    drive(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);   // load-use and branch together
    @(negedge clk);
    n_tests++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      n_fail++;
      $display("FAIL br_over_stall: got %b expected 0011", {stall_f, stall_d, flush_d, flush_e});
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 32'd2) begin
      n_fail++; $display("FAIL br_counts: got %0d/%0d expected 1/2", stall_cnt, flush_cnt);
    end
    tick();
    nops(3);
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);   // lw x7
    tick();
    drive(5'd0, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);   // use x7 via rs2
    #2;
    n_tests++;
    if (stall_d !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_stall: got %b expected 1", stall_d);
    end
    rst = 1'b1;
    pc_src_e = 1'b1;
    #1;
    n_tests++;
    if ({fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e} !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_async_outputs: got %b expected 00000000",
               {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e});
    end
    n_tests++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_async_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    drive(5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);   // lw x7, 0(x7): stalls every other cycle
    for (int i = 0; i < 40; i++) tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== 32'd20) begin
      n_fail++; $display("FAIL sat_wide_cnt: got %0d expected 20", stall_cnt);
    end
    n_tests++;
    if (s_stall_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_narrow_cnt: got %0d expected 15", s_stall_cnt);
    end
    n_tests++;
    if (s_flush_cnt !== 4'd0) begin
      n_fail++; $display("FAIL sat_narrow_flush: got %0d expected 0", s_flush_cnt);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_ex_forward();
    test_wb_priority();
    test_load_use();
    test_x0_guard();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
